cov_stim_gen: RTL and testbench

Synthesizable stimulus generator that produces 5-bit operand pairs for the coverage DUT's `a_in`/`b_in` inputs over a valid/ready handshake. It replaces free-running `$random` driving with a reproducible, counted, mode-selectable source. It is the driving end of the interface whose outputs the bound functional-coverage monitor samples. One run emits exactly `count_in` transfers, then reports done.

---
 rtl/cov_stim_gen.sv | 131 +++++++++++++
 tb/tb_cov_stim_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cov_stim_gen.sv
// rtl/cov_stim_gen.sv - counted, mode-selectable operand-pair stimulus source
// Emits count_in pairs over valid/ready in LFSR, sweep or corner mode, then reports done.
module cov_stim_gen #(
    parameter logic [4:0] SEED_A = 5'h01,
    parameter logic [4:0] SEED_B = 5'h1F,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [1:0]       mode_in,
    input  logic [CNT_W-1:0] count_in,
    input  logic             ready_in,
    output logic [4:0]       a_ou,
    output logic [4:0]       b_ou,
    output logic             valid_ou,
    output logic             busy_ou,
    output logic             done_ou,
    output logic [CNT_W-1:0] sent_ou
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0]       SEED_A_EFF = (SEED_A == 5'h00) ? 5'h01 : SEED_A;
    localparam logic [4:0]       SEED_B_EFF = (SEED_B == 5'h00) ? 5'h01 : SEED_B;
    localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] count_q, sent_q, sent_d;
    logic [9:0]       sweep_q, sweep_d;
    logic [1:0]       corner_q, corner_d;
    logic [4:0]       a_q, b_q, a_d, b_d;
    logic             valid_q, busy_q, done_q;
    logic             xfer, last;

    // In LFSR mode the output registers double as the LFSR state.
    always_comb begin
        sweep_d  = sweep_q + 10'd1;
        corner_d = corner_q + 2'd1;
        sent_d   = sent_q + ONE;
        last     = (sent_d == count_q);
        xfer     = valid_q & ready_in;
        case (mode_q)
            2'd1: begin
                a_d = sweep_d[4:0];
                b_d = sweep_d[9:5];
            end
            2'd2: begin
                a_d = {5{corner_d[1]}};
                b_d = {5{corner_d[0]}};
            end
            default: begin
                a_d = {a_q[3:0], a_q[4] ^ a_q[2]};
                b_d = {b_q[3:0], b_q[4] ^ b_q[2]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            count_q  <= '0;
            sent_q   <= '0;
            sweep_q  <= 10'd0;
            corner_q <= 2'd0;
            a_q      <= 5'd0;
            b_q      <= 5'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_in) begin
                        mode_q   <= mode_in;
                        count_q  <= count_in;
                        sent_q   <= '0;
                        sweep_q  <= 10'd0;
                        corner_q <= 2'd0;
                        if (mode_in == 2'd1 || mode_in == 2'd2) begin
                            a_q <= 5'd0;
                            b_q <= 5'd0;
                        end else begin
                            a_q <= SEED_A_EFF;
                            b_q <= SEED_B_EFF;
                        end
                        if (count_in == '0) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        sent_q   <= sent_d;
                        sweep_q  <= sweep_d;
                        corner_q <= corner_d;
                        // The final pair stays on the outputs through DONE.
                        if (last) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            a_q <= a_d;
                            b_q <= b_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ou     = a_q;
    assign b_ou     = b_q;
    assign valid_ou = valid_q;
    assign busy_ou  = busy_q;
    assign done_ou  = done_q;
    assign sent_ou  = sent_q;

endmodule

// File: tb/tb_cov_stim_gen.sv
// tb/tb_cov_stim_gen.sv - randomized self-checking bench for cov_stim_gen
// Observed transfers are compared against an arithmetic model of the three generator modes.
module tb_cov_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic [15:0] count_in = 16'd0;
    logic        ready_in = 1'b0;
    logic [4:0]  a_ou, b_ou;
    logic        valid_ou, busy_ou, done_ou;
    logic [15:0] sent_ou;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] got_a[$];
    logic [4:0] got_b[$];
    int hold_err, drop_err, timeout, cycles;
    logic first_valid, first_busy, first_done;

    cov_stim_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start_in),
        .mode_in  (mode_in),
        .count_in (count_in),
        .ready_in (ready_in),
        .a_ou     (a_ou),
        .b_ou     (b_ou),
        .valid_ou (valid_ou),
        .busy_ou  (busy_ou),
        .done_ou  (done_ou),
        .sent_ou  (sent_ou)
    );

    always #5 clk = ~clk;

    // Pair k (0-based) of a run, returned as {b, a}.
    function automatic logic [9:0] model_pair(input int mode, input int k);
        int a, b, v;
        case (mode)
            1: begin
                v = k % 1024;
                a = v % 32;
                b = v / 32;
            end
            2: begin
                v = k % 4;
                a = (v >= 2) ? 31 : 0;
                b = (v % 2 == 1) ? 31 : 0;
            end
            default: begin
                a = 1;
                b = 31;
                repeat (k) begin
                    a = (a * 2) % 32 + ((a / 16) + (a / 4)) % 2;
                    b = (b * 2) % 32 + ((b / 16) + (b / 4)) % 2;
                end
            end
        endcase
        return {b[4:0], a[4:0]};
    endfunction

    // rdy_kind: 0 = always ready, 1 = toggle starting at 0, 2 = random.
    task automatic drive_run(input int mode, input int count, input int rdy_kind,
                             input int poke_at, input int budget);
        logic       prev_valid, prev_ready, r;
        logic [4:0] prev_a, prev_b;
        got_a.delete();
        got_b.delete();
        hold_err = 0; drop_err = 0; timeout = 0; cycles = 0;
        mode_in  = mode[1:0];
        count_in = count[15:0];
        ready_in = 1'b0;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in    = 1'b0;
        first_valid = valid_ou;
        first_busy  = busy_ou;
        first_done  = done_ou;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        prev_a      = 5'd0;
        prev_b      = 5'd0;
        while (!done_ou) begin
            if (cycles >= budget) begin
                timeout = 1;
                break;
            end
            if (prev_valid && !prev_ready) begin
                if (!valid_ou) drop_err++;
                else if (a_ou !== prev_a || b_ou !== prev_b) hold_err++;
            end
            if (rdy_kind == 0) r = 1'b1;
            else if (rdy_kind == 1) r = (cycles % 2 == 1);
            else r = 1'($urandom_range(0, 1));
            ready_in = r;
            if (cycles == poke_at) begin
                start_in = 1'b1;
                mode_in  = 2'd2;
                count_in = 16'd3;
            end else begin
                start_in = 1'b0;
            end
            prev_valid = valid_ou;
            prev_ready = r;
            prev_a     = a_ou;
            prev_b     = b_ou;
            @(posedge clk);
            if (prev_valid && r) begin
                got_a.push_back(prev_a);
                got_b.push_back(prev_b);
            end
            #1;
            cycles++;
        end
        start_in = 1'b0;
        ready_in = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (valid_ou !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_ou); end
        n_checks++; if (busy_ou !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_ou); end
        n_checks++; if (done_ou !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_ou); end
        n_checks++; if (sent_ou !== 16'd0) begin n_fail++; $display("FAIL reset_sent got %0d want 0", sent_ou); end
        n_checks++; if ({a_ou, b_ou} !== 10'd0) begin n_fail++; $display("FAIL reset_pair got (%0d,%0d) want (0,0)", a_ou, b_ou); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lfsr_full_rate;
        logic [9:0] exp;
        drive_run(0, 5, 0, -1, 50);
        n_checks++; if (first_valid !== 1'b1 || first_busy !== 1'b1) begin n_fail++; $display("FAIL lfsr_first valid=%b busy=%b want 1,1", first_valid, first_busy); end
        n_checks++; if (timeout != 0 || got_a.size() != 5) begin n_fail++; $display("FAIL lfsr_count got %0d transfers timeout=%0d want 5", got_a.size(), timeout); end
        for (int i = 0; i < got_a.size(); i++) begin
            exp = model_pair(0, i);
            n_checks++; if ({got_b[i], got_a[i]} !== exp) begin n_fail++; $display("FAIL lfsr_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_a[i], got_b[i], exp[4:0], exp[9:5]); end
        end
        n_checks++; if (cycles != 5) begin n_fail++; $display("FAIL lfsr_throughput got %0d cycles want 5", cycles); end
        n_checks++; if (done_ou !== 1'b1 || valid_ou !== 1'b0 || busy_ou !== 1'b0) begin n_fail++; $display("FAIL lfsr_done d=%b v=%b b=%b want 1,0,0", done_ou, valid_ou, busy_ou); end
        n_checks++; if (sent_ou !== 16'd5) begin n_fail++; $display("FAIL lfsr_sent got %0d want 5", sent_ou); end
        exp = model_pair(0, 4);
        n_checks++; if ({b_ou, a_ou} !== exp) begin n_fail++; $display("FAIL lfsr_hold_last got (%0d,%0d) want (%0d,%0d)", a_ou, b_ou, exp[4:0], exp[9:5]); end
    endtask

    task automatic test_backpressure;
        logic [9:0] exp;
        drive_run(0, 3, 1, -1, 50);
        n_checks++; if (timeout != 0 || got_a.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", got_a.size()); end
        for (int i = 0; i < got_a.size(); i++) begin
            exp = model_pair(0, i);
            n_checks++; if ({got_b[i], got_a[i]} !== exp) begin n_fail++; $display("FAIL bp_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_a[i], got_b[i], exp[4:0], exp[9:5]); end
        end
        n_checks++; if (hold_err != 0 || drop_err != 0) begin n_fail++; $display("FAIL bp_stable hold_err=%0d drop_err=%0d want 0,0", hold_err, drop_err); end
        n_checks++; if (sent_ou !== 16'd3) begin n_fail++; $display("FAIL bp_sent got %0d want 3", sent_ou); end
    endtask

    task automatic test_random_modes;
        int mode, count, bad;
        logic [9:0] exp;
        for (int t = 0; t < 6; t++) begin
            mode  = $urandom_range(0, 3);
            count = $urandom_range(1, 70);
            drive_run(mode, count, 2, -1, count * 6 + 40);
            bad = 0;
            for (int i = 0; i < got_a.size(); i++) begin
                exp = model_pair(mode, i);
                if ({got_b[i], got_a[i]} !== exp) bad++;
            end
            n_checks++; if (timeout != 0 || got_a.size() != count) begin n_fail++; $display("FAIL rand%0d_count mode=%0d got %0d want %0d", t, mode, got_a.size(), count); end
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_pairs mode=%0d got %0d bad pairs want 0", t, mode, bad); end
            n_checks++; if (hold_err != 0 || drop_err != 0) begin n_fail++; $display("FAIL rand%0d_stable hold=%0d drop=%0d want 0,0", t, hold_err, drop_err); end
            n_checks++; if (sent_ou !== count[15:0]) begin n_fail++; $display("FAIL rand%0d_sent got %0d want %0d", t, sent_ou, count); end
        end
    endtask

    task automatic test_sweep;
        drive_run(1, 40, 2, -1, 400);
        n_checks++; if (timeout != 0 || got_a.size() != 40) begin n_fail++; $display("FAIL sweep_count got %0d want 40", got_a.size()); end
        else begin
            n_checks++; if ({got_a[0], got_b[0]} !== 10'd0) begin n_fail++; $display("FAIL sweep_first got (%0d,%0d) want (0,0)", got_a[0], got_b[0]); end
            n_checks++; if (got_a[32] !== 5'd0 || got_b[32] !== 5'd1) begin n_fail++; $display("FAIL sweep_33rd got (%0d,%0d) want (0,1)", got_a[32], got_b[32]); end
            n_checks++; if (got_a[39] !== 5'd7 || got_b[39] !== 5'd1) begin n_fail++; $display("FAIL sweep_last got (%0d,%0d) want (7,1)", got_a[39], got_b[39]); end
        end
        drive_run(1, 1025, 0, -1, 1100);
        n_checks++; if (timeout != 0 || got_a.size() != 1025) begin n_fail++; $display("FAIL sweep_wrap_count got %0d want 1025", got_a.size()); end
        n_checks++; if (a_ou !== 5'd0 || b_ou !== 5'd0) begin n_fail++; $display("FAIL sweep_wrap_last got (%0d,%0d) want (0,0)", a_ou, b_ou); end
        n_checks++; if (sent_ou !== 16'd1025) begin n_fail++; $display("FAIL sweep_wrap_sent got %0d want 1025", sent_ou); end
    endtask

    task automatic test_corners;
        logic [4:0] ea[6] = '{5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0};
        logic [4:0] eb[6] = '{5'd0, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31};
        drive_run(2, 6, 0, -1, 50);
        n_checks++; if (timeout != 0 || got_a.size() != 6) begin n_fail++; $display("FAIL corner_count got %0d want 6", got_a.size()); end
        for (int i = 0; i < got_a.size() && i < 6; i++) begin
            n_checks++; if (got_a[i] !== ea[i] || got_b[i] !== eb[i]) begin n_fail++; $display("FAIL corner_pair%0d got (%0d,%0d) want (%0d,%0d)", i, got_a[i], got_b[i], ea[i], eb[i]); end
        end
    endtask

    task automatic test_zero_count;
        int pulses;
        drive_run(0, 0, 0, -1, 20);
        n_checks++; if (first_done !== 1'b1 || first_valid !== 1'b0) begin n_fail++; $display("FAIL zero_first done=%b valid=%b want 1,0", first_done, first_valid); end
        n_checks++; if (sent_ou !== 16'd0) begin n_fail++; $display("FAIL zero_sent got %0d want 0", sent_ou); end
        pulses = 0;
        ready_in = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid_ou) pulses++;
        end
        ready_in = 1'b0;
        n_checks++; if (pulses != 0 || got_a.size() != 0) begin n_fail++; $display("FAIL zero_no_valid got %0d pulses want 0", pulses); end
    endtask

    task automatic test_back_to_back;
        drive_run(1, 4, 0, -1, 50);
        n_checks++; if (first_done !== 1'b0 || first_valid !== 1'b1 || first_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart done=%b valid=%b busy=%b want 0,1,1", first_done, first_valid, first_busy); end
        n_checks++; if (sent_ou !== 16'd4 || got_a.size() != 4) begin n_fail++; $display("FAIL b2b_sent got %0d want 4", sent_ou); end
    endtask

    task automatic test_start_ignored;
        int bad;
        logic [9:0] exp;
        drive_run(1, 10, 0, 3, 60);
        bad = 0;
        for (int i = 0; i < got_a.size(); i++) begin
            exp = model_pair(1, i);
            if ({got_b[i], got_a[i]} !== exp) bad++;
        end
        n_checks++; if (got_a.size() != 10 || bad != 0) begin n_fail++; $display("FAIL start_ignored got %0d transfers %0d bad want 10,0", got_a.size(), bad); end
        n_checks++; if (sent_ou !== 16'd10) begin n_fail++; $display("FAIL start_ignored_sent got %0d want 10", sent_ou); end
    endtask

    task automatic test_reset_mid_run;
        mode_in = 2'd0; count_in = 16'd20; ready_in = 1'b1; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({valid_ou, busy_ou, done_ou} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags got %b want 000", {valid_ou, busy_ou, done_ou}); end
        n_checks++; if (sent_ou !== 16'd0 || a_ou !== 5'd0 || b_ou !== 5'd0) begin n_fail++; $display("FAIL rstmid_data sent=%0d a=%0d b=%0d want 0", sent_ou, a_ou, b_ou); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_in = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (valid_ou !== 1'b0 || busy_ou !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle valid=%b busy=%b want 0,0", valid_ou, busy_ou); end
        drive_run(0, 2, 0, -1, 20);
        n_checks++; if (got_a.size() < 1 || got_a[0] !== 5'd1 || got_b[0] !== 5'd31) begin n_fail++; $display("FAIL rstmid_replay got %0d transfers first (%0d,%0d) want (1,31)", got_a.size(), got_a.size() ? got_a[0] : 5'd0, got_b.size() ? got_b[0] : 5'd0); end
    endtask

    initial begin
        test_reset;
        test_lfsr_full_rate;
        test_backpressure;
        test_random_modes;
        test_sweep;
        test_corners;
        test_zero_count;
        test_back_to_back;
        test_start_ignored;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
